// File: rtl/dcsk_frame_chip_ctr.sv
// DCSK TX chip/bit sequencer: counts chips per reference/data half and bits per frame.
// Latency: chip 0 presented the cycle after an accepted start; all outputs but o_last_chip registered.
// Backpressure: i_en low stalls every counter indefinitely; i_clr aborts with priority.
module dcsk_frame_chip_ctr #(
    parameter int NUM_SF         = 4,
    parameter int SF_LOG2_MIN    = 2,
    parameter int BITS_PER_FRAME = 32,
    parameter int SFW            = (NUM_SF > 1) ? $clog2(NUM_SF) : 1,
    parameter int CHIP_W         = ((SF_LOG2_MIN + NUM_SF - 1) > 0) ? (SF_LOG2_MIN + NUM_SF - 1) : 1,
    parameter int BIT_W          = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_start,
    input  logic [SFW-1:0]    i_sf,
    input  logic              i_en,
    input  logic              i_clr,
    output logic              o_busy,
    output logic [CHIP_W-1:0] o_chip_index,
    output logic              o_data_half,
    output logic [BIT_W-1:0]  o_bit_index,
    output logic              o_last_chip,
    output logic [SFW-1:0]    o_sf_lat,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [SFW:0]       NUM_SF_W  = (SFW + 1)'(NUM_SF);
    localparam logic [SFW:0]       NUM_SF_M1 = (SFW + 1)'(NUM_SF - 1);
    localparam logic [CHIP_W-1:0]  CHIP_ONES = {CHIP_W{1'b1}};
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(BITS_PER_FRAME - 1);

    logic [0:0]        state_q, state_d;
    logic [CHIP_W-1:0] chip_q, chip_d;
    logic              half_q, half_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [SFW-1:0]    sf_lat_q, sf_lat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [SFW:0]      chip_shamt;
    logic [CHIP_W-1:0] chip_max;
    logic              run;
    logic              last_chip;
    logic              sf_valid;

    // SF-1 is a run of ones; the largest SF code uses the full chip index width.
    assign chip_shamt = NUM_SF_M1 - {1'b0, sf_lat_q};
    assign chip_max   = CHIP_ONES >> chip_shamt;
    assign run        = (state_q == S_RUN);
    assign last_chip  = run && (chip_q == chip_max) && half_q && (bit_q == LAST_BIT);
    assign sf_valid   = ({1'b0, i_sf} < NUM_SF_W);

    always_comb begin
        state_d  = state_q;
        chip_d   = chip_q;
        half_d   = half_q;
        bit_d    = bit_q;
        sf_lat_d = sf_lat_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (i_clr) begin
            state_d = S_IDLE;
            chip_d  = '0;
            half_d  = 1'b0;
            bit_d   = '0;
        end else if (!run) begin
            chip_d = '0;
            half_d = 1'b0;
            bit_d  = '0;
            if (i_start) begin
                if (sf_valid) begin
                    state_d  = S_RUN;
                    sf_lat_d = i_sf;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (i_en) begin
            if (last_chip) begin
                state_d = S_IDLE;
                chip_d  = '0;
                half_d  = 1'b0;
                bit_d   = '0;
                done_d  = 1'b1;
            end else if (chip_q == chip_max) begin
                chip_d = '0;
                half_d = ~half_q;
                if (half_q) begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end else begin
                chip_d = chip_q + CHIP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q  <= S_IDLE;
            chip_q   <= '0;
            half_q   <= 1'b0;
            bit_q    <= '0;
            sf_lat_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            chip_q   <= chip_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            sf_lat_q <= sf_lat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_busy       = run;
    assign o_chip_index = chip_q;
    assign o_data_half  = half_q;
    assign o_bit_index  = bit_q;
    assign o_last_chip  = last_chip;
    assign o_sf_lat     = sf_lat_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_dcsk_frame_chip_ctr.sv
// Directed bench for dcsk_frame_chip_ctr: vector table plus hand-written multi-cycle sequences.
module tb_dcsk_frame_chip_ctr;

    localparam int BPF = 4;

    logic       clk;
    logic       arst_n;
    logic       start;
    logic [1:0] sf_in;
    logic       en;
    logic       clr;

    logic       o_busy;
    logic [4:0] o_chip;
    logic       o_half;
    logic [1:0] o_bit;
    logic       o_last;
    logic [1:0] o_sflat;
    logic       o_done;
    logic       o_err;

    logic       start_b;
    logic [1:0] sf_b;
    logic       ob_busy;
    logic [3:0] ob_chip;
    logic       ob_half;
    logic [1:0] ob_bit;
    logic       ob_last;
    logic [1:0] ob_sflat;
    logic       ob_done;
    logic       ob_err;

    int n_vec;
    int n_bad;

    dcsk_frame_chip_ctr #(.NUM_SF(4), .SF_LOG2_MIN(2), .BITS_PER_FRAME(BPF)) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_sf(sf_in), .i_en(en), .i_clr(clr),
        .o_busy(o_busy), .o_chip_index(o_chip), .o_data_half(o_half), .o_bit_index(o_bit),
        .o_last_chip(o_last), .o_sf_lat(o_sflat), .o_done(o_done), .o_err(o_err)
    );

    // Three codes in a 2-bit field leaves code 3 free to exercise the invalid-SF path.
    dcsk_frame_chip_ctr #(.NUM_SF(3), .SF_LOG2_MIN(2), .BITS_PER_FRAME(BPF)) dut_b (
        .i_clk(clk), .i_arst_n(arst_n), .i_start(start_b), .i_sf(sf_b), .i_en(en), .i_clr(clr),
        .o_busy(ob_busy), .o_chip_index(ob_chip), .o_data_half(ob_half), .o_bit_index(ob_bit),
        .o_last_chip(ob_last), .o_sf_lat(ob_sflat), .o_done(ob_done), .o_err(ob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] sf;
        logic       en;
        logic       clr;
        logic       busy;
        int         chip;
        logic       half;
        int         bt;
        logic       last;
        logic       done;
        logic       err;
        int         sflat;
    } vec_t;

    vec_t tbl[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic b, input int chip, input logic h, input int bt,
                       input logic l, input logic d, input logic e, input int sfl);
        n_vec++;
        if (o_busy !== b || int'(o_chip) != chip || o_half !== h || int'(o_bit) != bt ||
            o_last !== l || o_done !== d || o_err !== e || int'(o_sflat) != sfl) begin
            n_bad++;
            $display("FAIL %s: got busy=%0b chip=%0d half=%0b bit=%0d last=%0b done=%0b err=%0b sf=%0d, want busy=%0b chip=%0d half=%0b bit=%0d last=%0b done=%0b err=%0b sf=%0d",
                     name, o_busy, o_chip, o_half, o_bit, o_last, o_done, o_err, o_sflat,
                     b, chip, h, bt, l, d, e, sfl);
        end
    endtask

    task automatic chk_b(input string name, input logic b, input logic e, input int sfl);
        n_vec++;
        if (ob_busy !== b || ob_err !== e || int'(ob_sflat) != sfl || ob_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got busy=%0b err=%0b sf=%0d done=%0b, want busy=%0b err=%0b sf=%0d done=0",
                     name, ob_busy, ob_err, ob_sflat, ob_done, b, e, sfl);
        end
    endtask

    // Expected position after n enabled chips, from plain division of the chip count.
    task automatic chk_run(input string name, input int n, input int sf, input int code);
        chk(name, 1'b1, n % sf, logic'((n / sf) % 2), n / (2 * sf), (n == 2 * sf * BPF - 1),
            1'b0, 1'b0, code);
    endtask

    task automatic run_full(input logic [1:0] code);
        int sf;
        sf = 4 << code;
        start = 1'b1; sf_in = code; en = 1'b1; clr = 1'b0;
        step();
        start = 1'b0;
        for (int n = 0; n < 2 * sf * BPF; n++) begin
            chk_run($sformatf("full_sf%0d_n%0d", sf, n), n, sf, int'(code));
            step();
        end
        chk($sformatf("full_sf%0d_done", sf), 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, int'(code));
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_bad = 0;

        //              start sf en clr | busy chip half bit last done err sflat
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3};

        arst_n = 1'b0;
        start = 1'b0; sf_in = 2'd0; en = 1'b0; clr = 1'b0;
        start_b = 1'b0; sf_b = 2'd0;
        #12;
        chk("in_reset", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        #5;
        arst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start; sf_in = tbl[i].sf; en = tbl[i].en; clr = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d", i), tbl[i].busy, tbl[i].chip, tbl[i].half, tbl[i].bt,
                tbl[i].last, tbl[i].done, tbl[i].err, tbl[i].sflat);
        end
        start = 1'b0; clr = 1'b0;

        // Full SF4 frame, then a back-to-back SF32 start in the done cycle.
        run_full(2'd0);
        start = 1'b1; sf_in = 2'd3; en = 1'b1;
        step();
        start = 1'b0;

        // SF32 with alternating enable; live i_sf changed mid-frame must not matter.
        n = 0;
        for (int c = 0; c < 511; c++) begin
            chk_run($sformatf("stall_c%0d", c), n, 32, 3);
            en = (c % 2 == 0);
            if (c == 100) sf_in = 2'd0;
            if (c == 300) start = 1'b1;
            if (c == 302) start = 1'b0;
            step();
            if (en) n++;
        end
        chk("stall_done", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3);
        en = 1'b1;
        step();
        chk("after_done", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);

        // Invalid SF code on the 3-code instance.
        sf_b = 2'd3; start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk_b("err_pulse", 1'b0, 1'b1, 0);
        step();
        chk_b("err_clear", 1'b0, 1'b0, 0);
        sf_b = 2'd2; start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk_b("b_valid_start", 1'b1, 1'b0, 2);

        // Abort at bit 2, chip 1, data half.
        start = 1'b1; sf_in = 2'd0; en = 1'b1; clr = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 21; k++) step();
        chk_run("pre_clr", 21, 4, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_idle", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        en = 1'b0;
        step();
        chk("clr_no_done", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_full(2'd1);

        // Asynchronous reset between clock edges in the middle of a frame.
        start = 1'b1; sf_in = 2'd2; en = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_run("pre_arst", 2, 16, 2);
        #3;
        arst_n = 1'b0;
        #1;
        chk("arst_immediate", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        #3;
        arst_n = 1'b1;
        step();
        chk("arst_release", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("arst_idle", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        start = 1'b1; sf_in = 2'd1;
        step();
        start = 1'b0;
        chk("arst_restart", 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
